// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control FSM for a 4-digit BCD stopwatch built around an external
// cascaded decade-counter chain.
//
// Parameters:
//   DIV        clk cycles per count tick (2..2^20)
// Ports:
//   clk        system clock, rising-edge active
//   cr         asynchronous active-high reset
//   key_start  debounced start/stop button level (asynchronous)
//   key_lap    debounced lap button level (asynchronous)
//   key_clr    debounced clear button level (asynchronous)
//   bcd_in     live BCD count from the counter chain, [15:12] most significant
//   cnt_en     count-enable pulse to the least-significant decade counter
//   cnt_clr    one-cycle clear request to the counter chain
//   disp       BCD value for the display driver
//   state      FSM state (IDLE=00, RUN=01, STOP=10, LAP=11)
//   ovf        sticky overflow flag
module stopwatch_ctrl #(
    parameter int DIV = 500000
) (
    input  logic        clk,
    input  logic        cr,
    input  logic        key_start,
    input  logic        key_lap,
    input  logic        key_clr,
    input  logic [15:0] bcd_in,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        ovf
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STOP = 2'b10;
    localparam logic [1:0] LAP  = 2'b11;

    localparam int PW = 20;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // Key vectors are ordered {clr, lap, start}.
    logic [2:0]    keys;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    prev;
    logic [2:0]    armed;
    logic [1:0]    settle;
    logic [2:0]    key_edge;
    logic [PW-1:0] presc;
    logic [15:0]   lap_reg;
    logic          running;
    logic          tick;
    logic          overflow;
    logic          ev_start;
    logic          ev_lap;
    logic          ev_clr;
    logic [1:0]    state_nxt;
    logic          ovf_nxt;
    logic          lap_load;
    logic          clr_act;

    assign keys = {key_clr, key_lap, key_start};

    // A key only acts on a rising edge seen after the synchronizer has
    // refilled following reset and the key has been observed low. This
    // keeps a button held through reset release from firing an event.
    assign key_edge = sync2 & ~prev & armed;

    // Priority clr > start > lap; only the winner is ever considered.
    assign ev_clr   = key_edge[2];
    assign ev_start = key_edge[0] & ~key_edge[2];
    assign ev_lap   = key_edge[1] & ~key_edge[2] & ~key_edge[0];

    assign running  = (state == RUN) || (state == LAP);
    assign tick     = running && (presc == PRESC_MAX);
    assign overflow = tick && (bcd_in == 16'h9999);
    assign cnt_en   = tick && !overflow;
    assign disp     = (state == LAP) ? lap_reg : bcd_in;

    // Next-state logic. An overflow tick overrides any key event that
    // arrives in the same cycle and parks the watch in STOP.
    always_comb begin
        state_nxt = state;
        ovf_nxt   = ovf;
        lap_load  = 1'b0;
        clr_act   = 1'b0;
        if (overflow) begin
            state_nxt = STOP;
            ovf_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_clr) begin
                        clr_act = 1'b1;
                    end else if (ev_start) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (ev_start) begin
                        state_nxt = STOP;
                    end else if (ev_lap) begin
                        state_nxt = LAP;
                        lap_load  = 1'b1;
                    end
                end
                LAP: begin
                    if (ev_start) begin
                        state_nxt = STOP;
                    end else if (ev_lap) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    if (ev_clr) begin
                        state_nxt = IDLE;
                        ovf_nxt   = 1'b0;
                        clr_act   = 1'b1;
                    end else if (ev_start && !ovf) begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    // Key synchronizers, edge detectors and the post-reset arming logic.
    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            sync1  <= 3'b000;
            sync2  <= 3'b000;
            prev   <= 3'b000;
            armed  <= 3'b000;
            settle <= 2'd0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            prev  <= sync2;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            armed <= armed | ({3{settle == 2'd2}} & ~sync2);
        end
    end

    // Prescaler runs only while counting and sits at zero otherwise, so
    // every resumed run starts with a full tick period.
    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            presc <= '0;
        end else if (running && !(presc == PRESC_MAX)) begin
            presc <= presc + 1'b1;
        end else begin
            presc <= '0;
        end
    end

    // FSM state, sticky overflow, lap capture and registered clear pulse.
    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            state   <= IDLE;
            ovf     <= 1'b0;
            lap_reg <= 16'h0000;
            cnt_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            ovf     <= ovf_nxt;
            cnt_clr <= clr_act;
            if (lap_load) begin
                lap_reg <= bcd_in;
            end
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DIV, default 500000, clk cycles per count tick (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 cr  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 key_start  input  1  debounced start/stop button level, asynchronous to clk.
REQ-005 key_lap  input  1  debounced lap button level, asynchronous to clk.
REQ-006 key_clr  input  1  debounced clear button level, asynchronous to clk.
REQ-007 bcd_in  input  16  live 4-digit BCD count from the cascaded decade-counter chain, [15:12] most significant.
REQ-008 cnt_en  output  1  count-enable pulse to the least-significant decade counter.
REQ-009 cnt_clr  output  1  one-cycle active-high clear request to the counter chain.
REQ-010 disp  output  16  BCD value for the display driver.
REQ-011 state  output  2  FSM state: IDLE=00, RUN=01, STOP=10, LAP=11.
REQ-012 ovf  output  1  sticky overflow flag.

Function
REQ-013 Each key SHALL pass through a 2-FF synchronizer, then a rising-edge detector; only edges act, held levels are ignored.
REQ-014 A key level first high before clk edge k SHALL produce its action at edge k+2, i.e. the state register updates on the third edge.
REQ-015 Simultaneous key events in one cycle SHALL be resolved as clr > start > lap; exactly one event acts and the rest are discarded.
REQ-016 IDLE: start -> RUN; clr -> stays IDLE and pulses cnt_clr; lap is ignored.
REQ-017 RUN: start -> STOP; lap -> LAP and latches bcd_in into the lap register on the same edge; clr is ignored.
REQ-018 LAP: lap -> RUN; start -> STOP; clr is ignored; counting continues in LAP.
REQ-019 STOP: start -> RUN when ovf=0 and is ignored when ovf=1; clr -> IDLE, pulses cnt_clr and clears ovf; lap is ignored.
REQ-020 The prescaler SHALL count 0..DIV-1 and wrap only while state is RUN or LAP. It SHALL be held at 0 in IDLE and STOP, so a resumed run begins a full tick period.
REQ-021 cnt_en SHALL be high for exactly the one cycle in which the prescaler equals DIV-1 while in RUN or LAP; otherwise it is 0.
REQ-022 Overflow: if a tick occurs with bcd_in==16'h9999, cnt_en SHALL be suppressed that cycle. On that edge the FSM goes to STOP and ovf is set to 1.
REQ-023 Overflow SHALL take priority over a same-cycle start or lap event.
REQ-024 cnt_clr SHALL be registered, high for exactly the one cycle after the clear-action edge, and never asserted with cnt_en.
REQ-025 disp SHALL equal the lap register in LAP and bcd_in combinationally in all other states.

Reset
REQ-026 While cr=1: state=IDLE, cnt_en=0, cnt_clr=0, ovf=0, prescaler=0, lap register=0, synchronizers and edge detectors=0.
REQ-027 Assertion of cr mid-run SHALL immediately force these values with no cnt_en glitch. cnt_clr is not pulsed by reset.
REQ-028 A key level held high across reset release SHALL NOT produce an event until it is released and pressed again.

Verification (DIV=4)
REQ-029 Start from IDLE -> state=RUN at the third edge; cnt_en pulses every 4th cycle, the first pulse 4 cycles after entering RUN.
REQ-030 Lap in RUN with bcd_in=16'h0123, then bcd_in advancing -> disp holds 16'h0123 in LAP; a second lap makes disp follow bcd_in again.
REQ-031 RUN with bcd_in=16'h9999 at a tick -> no cnt_en, state=STOP, ovf=1; a later start is ignored; clr -> IDLE, one cnt_clr pulse, ovf=0.
REQ-032 start and clr edges in the same cycle while in STOP -> clr wins: state=IDLE, cnt_clr pulses once.
REQ-033 Assert cr while in LAP at prescaler=2 -> all outputs are immediately at reset values; key_start held through reset release produces no event.
REQ-034 Start, stop after 6 cycles, start again -> the prescaler restarts at 0, and exactly 2 cnt_en pulses occur in the first 8 run cycles after each start.
